// File: rtl/kw_ram_fifo_ctl.sv
// FIFO controller for a KW_ram_1ra_1ws_dff: owns the pointers, occupancy and status flags.
// Data never passes through here; the pusher drives RAM data_in and the popper reads RAM data_out.
module kw_ram_fifo_ctl #(
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int AE_LEVEL   = 2,
    parameter int AF_LEVEL   = DEPTH - 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  push_valid,
    output logic                  push_ready,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output logic                  ram_cs_n,
    output logic                  ram_we_n,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   FULL_CNT  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AE_CNT    = (ADDR_WIDTH + 1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0]   AF_CNT    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_next;
    logic [ADDR_WIDTH-1:0] rd_ptr_next;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  push_fire;
    logic                  pop_fire;

    // Flags come from the registered count only, so ready/valid never depend
    // combinationally on push_valid or pop_ready.
    assign empty        = (count_q == '0);
    assign full         = (count_q == FULL_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign almost_full  = (count_q >= AF_CNT);

    assign push_ready = ~full;
    assign pop_valid  = ~empty;

    assign push_fire = push_valid & push_ready & ~clear;
    assign pop_fire  = pop_valid & pop_ready & ~clear;

    // Write strobe and address must settle before the edge where the RAM samples them.
    assign ram_we_n    = ~push_fire;
    assign ram_cs_n    = ~(push_fire | ~empty);
    assign ram_wr_addr = wr_ptr_q;
    assign ram_rd_addr = rd_ptr_q;
    assign count       = count_q;

    always_comb begin
        wr_ptr_next = wr_ptr_q;
        rd_ptr_next = rd_ptr_q;
        count_next  = count_q;
        if (clear) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_fire) begin
                wr_ptr_next = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + ADDR_ONE;
            end
            if (pop_fire) begin
                rd_ptr_next = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + ADDR_ONE;
            end
            case ({push_fire, pop_fire})
                2'b10:   count_next = count_q + CNT_ONE;
                2'b01:   count_next = count_q - CNT_ONE;
                default: count_next = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_next;
            rd_ptr_q <= rd_ptr_next;
            count_q  <= count_next;
        end
    end

endmodule

// File: tb/tb_kw_ram_fifo_ctl.sv
// Bench for kw_ram_fifo_ctl with a behavioural 1-read/1-write RAM and a queue-based FIFO model.
module tb_kw_ram_fifo_ctl;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear = 1'b0;
    logic          push_valid = 1'b0;
    logic          pop_ready = 1'b0;
    logic          push_ready, pop_valid, ram_cs_n, ram_we_n;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [AW:0]   count;
    logic          empty, full, almost_empty, almost_full;

    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic [7:0] mem [DEPTH];

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    int         m_wr = 0;
    int         m_rd = 0;
    logic       last_we_n;
    logic       last_pop_valid;

    typedef struct {
        logic       pv;
        logic       pr;
        logic       cl;
        logic [7:0] din;
        logic       exp_we_n;
        logic       exp_pop_valid;
        int         exp_count;
    } vec_t;

    vec_t tbl[9];

    kw_ram_fifo_ctl #(.DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear        (clear),
        .push_valid   (push_valid),
        .push_ready   (push_ready),
        .pop_valid    (pop_valid),
        .pop_ready    (pop_ready),
        .ram_cs_n     (ram_cs_n),
        .ram_we_n     (ram_we_n),
        .ram_wr_addr  (ram_wr_addr),
        .ram_rd_addr  (ram_rd_addr),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full)
    );

    always #5 clock = ~clock;

    // RAM: synchronous write, asynchronous read.
    always @(posedge clock) begin
        if (!ram_cs_n && !ram_we_n) mem[ram_wr_addr] <= data_in;
    end
    assign data_out = mem[ram_rd_addr];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input logic pv, input logic cl);
        int   n;
        logic pf;
        n  = exp_q.size();
        pf = pv && (n < DEPTH) && !cl;
        chk("count", int'(count), n);
        chk("empty", int'(empty), int'(n == 0));
        chk("full", int'(full), int'(n == DEPTH));
        chk("almost_empty", int'(almost_empty), int'(n <= 2));
        chk("almost_full", int'(almost_full), int'(n >= DEPTH - 2));
        chk("push_ready", int'(push_ready), int'(n != DEPTH));
        chk("pop_valid", int'(pop_valid), int'(n != 0));
        chk("ram_wr_addr", int'(ram_wr_addr), m_wr);
        chk("ram_rd_addr", int'(ram_rd_addr), m_rd);
        chk("ram_we_n", int'(ram_we_n), int'(!pf));
        chk("ram_cs_n", int'(ram_cs_n), int'(!(pf || n != 0)));
        if (n != 0) chk("data_out", int'(data_out), int'(exp_q[0]));
    endtask

    task automatic model_edge(input logic pv, input logic pr, input logic cl, input logic [7:0] din);
        logic pf, qf;
        pf = pv && (exp_q.size() < DEPTH) && !cl;
        qf = pr && (exp_q.size() > 0) && !cl;
        if (cl) begin
            exp_q.delete();
            m_wr = 0;
            m_rd = 0;
        end else begin
            if (qf) begin
                void'(exp_q.pop_front());
                m_rd = (m_rd + 1) % DEPTH;
            end
            if (pf) begin
                exp_q.push_back(din);
                m_wr = (m_wr + 1) % DEPTH;
            end
        end
    endtask

    task automatic cycle(input logic pv, input logic pr, input logic cl, input logic [7:0] din);
        @(negedge clock);
        push_valid = pv;
        pop_ready  = pr;
        clear      = cl;
        data_in    = din;
        #1;
        check_outputs(pv, cl);
        last_we_n      = ram_we_n;
        last_pop_valid = pop_valid;
        @(posedge clock);
        model_edge(pv, pr, cl, din);
    endtask

    task automatic push_n(input int n, input int base);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 8'(base + i));
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 8'hA1, 1'b0, 1'b0, 1};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 8'hA2, 1'b0, 1'b1, 2};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 8'hA3, 1'b0, 1'b1, 2};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 8'hC0, 1'b1, 1'b1, 0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 8'hB0, 1'b0, 1'b0, 1};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 0};

        // Reset and idle
        repeat (2) @(negedge clock);
        #1;
        check_outputs(1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // Table-driven short sequence
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].pv, tbl[i].pr, tbl[i].cl, tbl[i].din);
            #1;
            chk($sformatf("tbl%0d_we_n", i), int'(last_we_n), int'(tbl[i].exp_we_n));
            chk($sformatf("tbl%0d_pop_valid", i), int'(last_pop_valid), int'(tbl[i].exp_pop_valid));
            chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].exp_count);
        end

        // Fill and drain
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        push_n(DEPTH, 0);
        #1;
        chk("fill_full", int'(full), 1);
        chk("fill_push_ready", int'(push_ready), 0);
        cycle(1'b1, 1'b0, 1'b0, 8'hEE);
        chk("fill_no_write", int'(last_we_n), 1);
        pop_n(DEPTH);
        #1;
        chk("drain_empty", int'(empty), 1);

        // Wrap-around
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        push_n(20, 8'h40);
        pop_n(20);
        push_n(20, 8'h80);
        #1;
        chk("wrap_wr_addr", int'(ram_wr_addr), 8);
        pop_n(20);

        // Simultaneous push/pop at count 5
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        push_n(5, 8'h10);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 8'(8'h20 + i));
        #1;
        chk("simul_count", int'(count), 5);
        chk("simul_wr_addr", int'(ram_wr_addr), 15);
        chk("simul_rd_addr", int'(ram_rd_addr), 10);
        pop_n(5);

        // Push and pop together at full
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        push_n(DEPTH, 8'h60);
        cycle(1'b1, 1'b1, 1'b0, 8'h55);
        chk("full_push_refused", int'(last_we_n), 1);
        #1;
        chk("full_pop_count", int'(count), DEPTH - 1);
        cycle(1'b1, 1'b0, 1'b0, 8'h56);
        chk("full_push_next", int'(last_we_n), 0);
        #1;
        chk("full_refill_count", int'(count), DEPTH);
        pop_n(DEPTH);

        // Clear with push and pop at count 7
        push_n(7, 8'h30);
        cycle(1'b1, 1'b1, 1'b1, 8'h77);
        chk("clear_no_write", int'(last_we_n), 1);
        #1;
        chk("clear_count", int'(count), 0);
        chk("clear_empty", int'(empty), 1);
        chk("clear_wr_addr", int'(ram_wr_addr), 0);
        chk("clear_rd_addr", int'(ram_rd_addr), 0);

        // Asynchronous reset mid-stream at count 12
        push_n(12, 8'h90);
        @(negedge clock);
        push_valid = 1'b1;
        pop_ready  = 1'b1;
        data_in    = 8'hAB;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_wr_addr", int'(ram_wr_addr), 0);
        chk("arst_rd_addr", int'(ram_rd_addr), 0);
        chk("arst_pop_valid", int'(pop_valid), 0);
        exp_q.delete();
        m_wr = 0;
        m_rd = 0;
        @(negedge clock);
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        reset_n    = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        push_n(3, 8'hC8);
        pop_n(3);

        // Randomized traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 99) == 0), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
